// File: rtl/alu_exec_unit.sv
// Execute stage: barrel shifter, 32-bit data-processing ALU, registered result and NZCV flags.
// Optional macro ALU_REG_SHIFT_EN enables register-specified shift amounts (EX_IR[4]=1 -> Rs).
module alu_exec_unit (
   input  logic        CLK,
   input  logic        rst,
   input  logic [31:0] A,
   input  logic [31:0] b,
   input  logic [3:0]  ALUop,
   input  logic        s,
   input  logic [31:0] EX_IR,
   input  logic [7:0]  Rs,
   input  logic [31:0] Rm,
   input  logic        MSR,
   output logic [31:0] S,
   output logic        N,
   output logic        Z,
   output logic        C,
   output logic        V,
   output logic [31:0] ALUout,
   output logic        Nout,
   output logic        Zout,
   output logic        Cout,
   output logic        Vout
);

   logic [31:0] r_alu_out;
   logic [3:0]  r_flags;

   logic        w_reg_shift;
   logic [7:0]  w_amt;
   logic [1:0]  w_type;
   logic [31:0] w_op2;
   logic        w_shc;
   logic [32:0] w_lsl;
   logic [32:0] w_lsr;
   logic [32:0] w_asr;
   logic [31:0] w_ror;
   logic [31:0] w_x;
   logic [31:0] w_y;
   logic        w_cin;
   logic        w_arith;
   logic [32:0] w_sum;
   logic [31:0] w_res;
   logic        w_unused_bits;

`ifdef ALU_REG_SHIFT_EN
   assign w_reg_shift = EX_IR[4];
   assign w_unused_bits = ^{EX_IR[31:26], EX_IR[24:12], EX_IR[3:0], Rm[27:0]};
`else
   assign w_reg_shift = 1'b0;
   assign w_unused_bits = ^{EX_IR[31:26], EX_IR[24:12], EX_IR[4:0], Rm[27:0], Rs};
`endif

   assign w_amt  = w_reg_shift ? Rs : {3'b000, EX_IR[11:7]};
   assign w_type = EX_IR[6:5];

   // Extra bit on each side of the shifted value captures the last bit shifted out.
   assign w_lsl = {1'b0, b} << w_amt;
   assign w_lsr = {b, 1'b0} >> w_amt;
   assign w_asr = $signed({b, 1'b0}) >>> w_amt;
   assign w_ror = (b >> w_amt[4:0]) | (b << (6'd32 - {1'b0, w_amt[4:0]}));

   always_comb begin
      w_op2 = b;
      w_shc = Cout;
      if (!EX_IR[25]) begin
         if (w_amt == 8'd0) begin
            // Immediate amount 0 encodes LSR/ASR #32 and RRX; register amount 0 is a pass-through.
            if (!w_reg_shift) begin
               case (w_type)
                  2'b01:   begin w_op2 = 32'd0;         w_shc = b[31]; end
                  2'b10:   begin w_op2 = {32{b[31]}};   w_shc = b[31]; end
                  2'b11:   begin w_op2 = {Cout, b[31:1]}; w_shc = b[0]; end
                  default: begin w_op2 = b;             w_shc = Cout;  end
               endcase
            end
         end else begin
            case (w_type)
               2'b00: begin
                  if (w_amt < 8'd32)       begin w_op2 = w_lsl[31:0]; w_shc = w_lsl[32]; end
                  else if (w_amt == 8'd32) begin w_op2 = 32'd0;       w_shc = b[0];      end
                  else                     begin w_op2 = 32'd0;       w_shc = 1'b0;      end
               end
               2'b01: begin
                  if (w_amt < 8'd32)       begin w_op2 = w_lsr[32:1]; w_shc = w_lsr[0]; end
                  else if (w_amt == 8'd32) begin w_op2 = 32'd0;       w_shc = b[31];    end
                  else                     begin w_op2 = 32'd0;       w_shc = 1'b0;     end
               end
               2'b10: begin
                  if (w_amt < 8'd32) begin w_op2 = w_asr[32:1];   w_shc = w_asr[0]; end
                  else               begin w_op2 = {32{b[31]}};   w_shc = b[31];    end
               end
               default: begin
                  if (w_amt[4:0] == 5'd0) begin w_op2 = b;     w_shc = b[31];     end
                  else                    begin w_op2 = w_ror; w_shc = w_ror[31]; end
               end
            endcase
         end
      end
   end

   // All arithmetic ops reduce to x + y + cin; subtraction inverts the subtrahend.
   always_comb begin
      w_x     = A;
      w_y     = w_op2;
      w_cin   = 1'b0;
      w_arith = 1'b1;
      case (ALUop)
         4'h2, 4'hA: begin w_y = ~w_op2; w_cin = 1'b1; end
         4'h3:       begin w_x = w_op2; w_y = ~A; w_cin = 1'b1; end
         4'h4, 4'hB: begin w_cin = 1'b0; end
         4'h5:       begin w_cin = Cout; end
         4'h6:       begin w_y = ~w_op2; w_cin = Cout; end
         4'h7:       begin w_x = w_op2; w_y = ~A; w_cin = Cout; end
         default:    begin w_arith = 1'b0; end
      endcase
   end

   assign w_sum = {1'b0, w_x} + {1'b0, w_y} + {32'd0, w_cin};

   always_comb begin
      w_res = w_sum[31:0];
      case (ALUop)
         4'h0, 4'h8: w_res = A & w_op2;
         4'h1, 4'h9: w_res = A ^ w_op2;
         4'hC:       w_res = A | w_op2;
         4'hD:       w_res = w_op2;
         4'hE:       w_res = A & ~w_op2;
         4'hF:       w_res = ~w_op2;
         default:    w_res = w_sum[31:0];
      endcase
   end

   assign S = w_res;
   assign N = w_res[31];
   assign Z = (w_res == 32'd0);
   assign C = w_arith ? w_sum[32] : w_shc;
   assign V = w_arith ? ((w_x[31] == w_y[31]) && (w_sum[31] != w_x[31])) : Vout;

   always_ff @(posedge CLK or negedge rst) begin
      if (!rst) begin
         r_alu_out <= 32'd0;
         r_flags   <= 4'd0;
      end else begin
         r_alu_out <= w_res;
         if (MSR)
            r_flags <= Rm[31:28];
         else if (s || (ALUop[3:2] == 2'b10))
            r_flags <= {N, Z, C, V};
      end
   end

   assign ALUout = r_alu_out;
   assign Nout   = r_flags[3];
   assign Zout   = r_flags[2];
   assign Cout   = r_flags[1];
   assign Vout   = r_flags[0];

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: directed corner cases plus randomized ops against a reference model.
module tb_alu_exec_unit;

   logic        CLK;
   logic        rst;
   logic [31:0] t_a;
   logic [31:0] t_b;
   logic [3:0]  t_op;
   logic        t_s;
   logic [31:0] t_ir;
   logic [7:0]  t_rs;
   logic [31:0] t_rm;
   logic        t_msr;
   logic [31:0] t_res;
   logic        t_n, t_z, t_c, t_v;
   logic [31:0] t_alu_out;
   logic        t_nout, t_zout, t_cout, t_vout;

   int n_checks = 0;
   int n_fail   = 0;

   logic [31:0] m_out;
   logic [3:0]  m_flags;

   alu_exec_unit dut (
      .CLK(CLK), .rst(rst), .A(t_a), .b(t_b), .ALUop(t_op), .s(t_s), .EX_IR(t_ir),
      .Rs(t_rs), .Rm(t_rm), .MSR(t_msr), .S(t_res), .N(t_n), .Z(t_z), .C(t_c), .V(t_v),
      .ALUout(t_alu_out), .Nout(t_nout), .Zout(t_zout), .Cout(t_cout), .Vout(t_vout)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, act, exp, $time);
      end
   endtask

   // Shifter modeled one bit at a time, following the rule table.
   task automatic model_eval(input logic [31:0] a, input logic [31:0] bb, input logic [3:0] op,
                             input logic [31:0] ir, input logic [7:0] rs, input logic [3:0] flags,
                             output logic [31:0] res, output logic [3:0] nzcv);
      logic [31:0] op2, val, x, y;
      logic        shc, c, v, cin, reg_sh, arith, sub;
      logic [7:0]  amt;
      logic [63:0] u;
      longint      r;
      int          n, brw, ci;
      cin = flags[1];
`ifdef ALU_REG_SHIFT_EN
      reg_sh = ir[4];
`else
      reg_sh = 1'b0;
`endif
      amt = reg_sh ? rs : {3'b000, ir[11:7]};
      if (ir[25]) begin
         op2 = bb; shc = cin;
      end else if (amt == 0) begin
         op2 = bb; shc = cin;
         if (!reg_sh) begin
            case (ir[6:5])
               2'd1: begin op2 = 0; shc = bb[31]; end
               2'd2: begin op2 = {32{bb[31]}}; shc = bb[31]; end
               2'd3: begin op2 = {cin, bb[31:1]}; shc = bb[0]; end
               default: ;
            endcase
         end
      end else begin
         n = int'(amt);
         if (ir[6:5] == 2'd3) n = (amt[4:0] == 0) ? 32 : int'(amt[4:0]);
         val = bb; c = cin;
         for (int i = 0; i < n; i++) begin
            case (ir[6:5])
               2'd0: begin c = val[31]; val = val << 1; end
               2'd1: begin c = val[0];  val = val >> 1; end
               2'd2: begin c = val[0];  val = {val[31], val[31:1]}; end
               default: begin c = val[0]; val = {val[0], val[31:1]}; end
            endcase
         end
         op2 = val; shc = c;
      end

      arith = 1'b1; sub = 1'b0; x = a; y = op2; brw = 0; ci = 0;
      case (op)
         4'h2, 4'hA: begin sub = 1'b1; brw = 0; end
         4'h3:       begin sub = 1'b1; x = op2; y = a; brw = 0; end
         4'h4, 4'hB: begin ci = 0; end
         4'h5:       begin ci = int'(cin); end
         4'h6:       begin sub = 1'b1; brw = cin ? 0 : 1; end
         4'h7:       begin sub = 1'b1; x = op2; y = a; brw = cin ? 0 : 1; end
         default:    arith = 1'b0;
      endcase
      c = shc; v = flags[0];
      case (op)
         4'h0, 4'h8: res = a & op2;
         4'h1, 4'h9: res = a ^ op2;
         4'hC:       res = a | op2;
         4'hD:       res = op2;
         4'hE:       res = a & ~op2;
         4'hF:       res = ~op2;
         default: begin
            if (sub) begin
               r = longint'($signed(x)) - longint'($signed(y)) - longint'(brw);
               c = ({32'd0, x} >= ({32'd0, y} + 64'(brw)));
            end else begin
               r = longint'($signed(x)) + longint'($signed(y)) + longint'(ci);
               u = {32'd0, x} + {32'd0, y} + 64'(ci);
               c = u[32];
            end
            res = r[31:0];
            v = (r > 64'sd2147483647) || (r < -64'sd2147483648);
         end
      endcase
      if (!arith) begin c = shc; v = flags[0]; end
      nzcv = {res[31], res == 32'd0, c, v};
   endtask

   // Called just after a falling edge; returns just after the next falling edge.
   task automatic run_cycle(input logic [31:0] a, input logic [31:0] bb, input logic [3:0] op,
                            input logic s_bit, input logic [31:0] ir, input logic [7:0] rs,
                            input logic [31:0] rm, input logic msr);
      logic [31:0] e_res;
      logic [3:0]  e_nzcv;
      t_a = a; t_b = bb; t_op = op; t_s = s_bit; t_ir = ir; t_rs = rs; t_rm = rm; t_msr = msr;
      #1;
      model_eval(a, bb, op, ir, rs, m_flags, e_res, e_nzcv);
      check("S", t_res, e_res);
      check("NZCV", {28'd0, t_n, t_z, t_c, t_v}, {28'd0, e_nzcv});
      @(posedge CLK);
      m_out = e_res;
      if (msr) m_flags = rm[31:28];
      else if (s_bit || (op >= 4'h8 && op <= 4'hB)) m_flags = e_nzcv;
      #1;
      check("ALUout", t_alu_out, m_out);
      check("flags_reg", {28'd0, t_nout, t_zout, t_cout, t_vout}, {28'd0, m_flags});
      @(negedge CLK);
   endtask

   function automatic logic [31:0] pick32();
      case ($urandom_range(0, 5))
         0: return 32'd0;
         1: return 32'hFFFF_FFFF;
         2: return 32'h7FFF_FFFF;
         3: return 32'h8000_0000;
         default: return $urandom;
      endcase
   endfunction

   initial begin
      logic [31:0] ir;
      logic [7:0]  rs;
      rst = 1'b0; t_a = 0; t_b = 0; t_op = 0; t_s = 0; t_ir = 0; t_rs = 0; t_rm = 0; t_msr = 0;
      m_out = 0; m_flags = 0;
      #2;
      check("reset_aluout", t_alu_out, 32'd0);
      check("reset_flags", {28'd0, t_nout, t_zout, t_cout, t_vout}, 32'd0);
      @(negedge CLK);
      rst = 1'b1;
      @(negedge CLK);

      // ADD overflow into sign bit
      run_cycle(32'h7FFF_FFFF, 32'd1, 4'h4, 1'b1, 32'h0200_0000, 8'd0, 32'd0, 1'b0);
      check("add_ovf_out", t_alu_out, 32'h8000_0000);
      check("add_ovf_flags", {28'd0, t_nout, t_zout, t_cout, t_vout}, 32'h9);
      // SUB to zero, then ADC without S holds flags
      run_cycle(32'd5, 32'd5, 4'h2, 1'b1, 32'h0200_0000, 8'd0, 32'd0, 1'b0);
      check("sub_zero_flags", {28'd0, t_nout, t_zout, t_cout, t_vout}, 32'h6);
      run_cycle(32'd1, 32'd1, 4'h5, 1'b0, 32'h0200_0000, 8'd0, 32'd0, 1'b0);
      check("adc_out", t_alu_out, 32'd3);
      check("adc_hold_flags", {28'd0, t_nout, t_zout, t_cout, t_vout}, 32'h6);
      // LSR #32 then RRX with carry set
      run_cycle(32'd0, 32'h8000_0001, 4'hD, 1'b1, 32'h0000_0020, 8'd0, 32'd0, 1'b0);
      check("lsr32_out", t_alu_out, 32'd0);
      check("lsr32_flags", {28'd0, t_nout, t_zout, t_cout, t_vout}, 32'h6);
      run_cycle(32'd0, 32'h8000_0001, 4'hD, 1'b1, 32'h0000_0060, 8'd0, 32'd0, 1'b0);
      check("rrx_out", t_alu_out, 32'hC000_0000);
      check("rrx_c", {31'd0, t_cout}, 32'd1);
      // CMP updates flags without S; MSR in the same cycle wins
      run_cycle(32'd3, 32'd4, 4'hA, 1'b0, 32'h0200_0000, 8'd0, 32'd0, 1'b0);
      check("cmp_flags", {28'd0, t_nout, t_zout, t_cout, t_vout}, 32'h8);
      run_cycle(32'd3, 32'd4, 4'hA, 1'b0, 32'h0200_0000, 8'd0, 32'h5000_0000, 1'b1);
      check("msr_wins", {28'd0, t_nout, t_zout, t_cout, t_vout}, 32'h5);
`ifdef ALU_REG_SHIFT_EN
      run_cycle(32'd0, 32'hFFFF_FFFF, 4'hD, 1'b1, 32'h0000_0010, 8'd33, 32'd0, 1'b0);
      check("lsl_rs33_out", t_alu_out, 32'd0);
      check("lsl_rs33_c", {31'd0, t_cout}, 32'd0);
      run_cycle(32'd0, 32'hFFFF_FFFF, 4'hD, 1'b1, 32'h0000_0010, 8'd32, 32'd0, 1'b0);
      check("lsl_rs32_out", t_alu_out, 32'd0);
      check("lsl_rs32_c", {31'd0, t_cout}, 32'd1);
`endif

      for (int i = 0; i < 400; i++) begin
         ir = $urandom;
         ir[25] = ($urandom_range(0, 3) == 0);
         case ($urandom_range(0, 5))
            0: rs = 8'd0;
            1: rs = 8'd1;
            2: rs = 8'd31;
            3: rs = 8'd32;
            4: rs = 8'd33;
            default: rs = 8'($urandom);
         endcase
         run_cycle(pick32(), pick32(), 4'($urandom_range(0, 15)), 1'($urandom), ir, rs,
                   $urandom, ($urandom_range(0, 7) == 0));
      end

      // Asynchronous reset mid-run, away from any clock edge
      run_cycle(32'd0, 32'h1234, 4'hD, 1'b1, 32'h0200_0000, 8'd0, 32'h0, 1'b1);
      run_cycle(32'd0, 32'h1234, 4'hD, 1'b0, 32'h0200_0000, 8'd0, 32'hF000_0000, 1'b1);
      check("pre_reset_out", t_alu_out, 32'h1234);
      #2 rst = 1'b0;
      #1;
      check("async_rst_out", t_alu_out, 32'd0);
      check("async_rst_flags", {28'd0, t_nout, t_zout, t_cout, t_vout}, 32'd0);
      m_out = 0; m_flags = 0;
      @(negedge CLK);
      rst = 1'b1;
      @(negedge CLK);
      run_cycle(32'd1, 32'd2, 4'h4, 1'b1, 32'h0200_0000, 8'd0, 32'd0, 1'b0);
      check("post_reset_add", t_alu_out, 32'd3);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
